mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits byte/half/word loads and stores into
// single-byte accesses on a synchronous-read 8-bit RAM, little-endian.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic [31:0] mem_a_out,
    output logic        mem_r_nw_out,
    output logic [7:0]  mem_d_out,
    input  logic [7:0]  mem_d_in
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << RAM_ADDR_WIDTH) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [2:0]  count;
    logic        we;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        accept;
    logic        last;
    logic [1:0]  idx_prev;
    logic [1:0]  idx_last;

    assign req_ready_out  = (state == IDLE) && rdy_in;
    assign accept         = req_valid_in && req_ready_out;
    assign last           = ({1'b0, idx} == (count - 3'd1));
    assign idx_prev       = idx - 2'd1;
    assign idx_last       = 2'(count - 3'd1);
    assign resp_valid_out = (state == DONE);
    assign resp_rdata_out = rdata;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (last) state_next = we ? DONE : WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load bytes arrive one cycle after being addressed, so each ACCESS edge
    // captures the previous index and WAIT captures the final one.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx   <= '0;
            count <= 3'd1;
            we    <= 1'b0;
            base  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else if (accept) begin
            idx   <= '0;
            we    <= req_we_in;
            base  <= req_addr_in & ADDR_MASK;
            wdata <= req_wdata_in;
            rdata <= '0;
            unique case (req_size_in)
                2'd0:    count <= 3'd1;
                2'd1:    count <= 3'd2;
                default: count <= 3'd4;
            endcase
        end else if (state == ACCESS) begin
            idx <= last ? 2'd0 : idx + 2'd1;
            if (!we && idx != 2'd0) begin
                rdata[{idx_prev, 3'b000} +: 8] <= mem_d_in;
            end
        end else if (state == WAIT) begin
            rdata[{idx_last, 3'b000} +: 8] <= mem_d_in;
        end
    end

    always_comb begin
        mem_a_out    = '0;
        mem_r_nw_out = 1'b1;
        mem_d_out    = '0;
        if (state == ACCESS) begin
            mem_a_out    = (base + 32'(idx)) & ADDR_MASK;
            mem_r_nw_out = ~we;
            mem_d_out    = wdata[{idx, 3'b000} +: 8];
        end
    end

endmodule
